// File: rtl/ball_pkg.sv
// Shared types and per-ball reset/colour tables for the multi-ball sprite generator.
package ball_pkg;

  typedef enum logic {IDLE, UPDATE} state_t;

  function automatic int init_x(int i);
    return 32 + 24 * i;
  endfunction

  function automatic int init_y(int i);
    return 32 + 16 * i;
  endfunction

  function automatic int init_vx(int i);
    return ((i % 2) == 1 ? -1 : 1) * (1 + (i % 3));
  endfunction

  function automatic int init_vy(int i);
    return ((i % 4) >= 2 ? -1 : 1) * 2;
  endfunction

  function automatic logic [2:0] ball_colour(int i);
    return 3'((i % 7) + 1);
  endfunction

endpackage

// File: rtl/ball_step.sv
// One-axis ball move: adds velocity, reflects and clamps at 0 and max.
module ball_step
  import ball_pkg::*;
#(
  parameter int POS_W = 9,
  parameter int VEL_W = 4
) (
  input  logic [POS_W-1:0]        x,
  input  logic signed [VEL_W-1:0] v,
  input  logic [POS_W-1:0]        max,
  output logic [POS_W-1:0]        x_next,
  output logic signed [VEL_W-1:0] v_next,
  output logic                    bounced
);

  logic signed [POS_W:0] nx;
  logic signed [POS_W:0] max_s;

  always_comb begin
    nx      = $signed({1'b0, x}) + $signed({{(POS_W + 1 - VEL_W){v[VEL_W-1]}}, v});
    max_s   = $signed({1'b0, max});
    x_next  = nx[POS_W-1:0];
    v_next  = v;
    bounced = 1'b0;
    // sign bit or zero: nx <= 0 without mixing signed/unsigned operands
    if (nx[POS_W] || (nx == '0)) begin
      x_next  = '0;
      v_next  = -v;
      bounced = 1'b1;
    end else if (nx >= max_s) begin
      x_next  = max;
      v_next  = -v;
      bounced = 1'b1;
    end
  end

endmodule

// File: rtl/ball_bounce_multi.sv
// Multi-ball bouncing sprite generator: per-frame sequential ball update and
// prioritised ball/grid pixel rendering from the beam position.
module ball_bounce_multi
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_ACTIVE  = 256,
  parameter int V_ACTIVE  = 240,
  parameter int POS_W     = 9,
  parameter int VEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 display_on,
  input  logic [POS_W-1:0]     hpos,
  input  logic [POS_W-1:0]     vpos,
  input  logic                 pause,
  input  logic [NUM_BALLS-1:0] ball_en,
  output logic [2:0]           rgb,
  output logic [NUM_BALLS-1:0] bounce_event
);

  localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [POS_W-1:0] XMAX = POS_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [POS_W-1:0] YMAX = POS_W'(V_ACTIVE - BALL_SIZE);
  localparam logic [POS_W-1:0] BS   = POS_W'(BALL_SIZE);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    vsync_q;
  logic                    tick;
  logic [POS_W-1:0]        x_r  [NUM_BALLS];
  logic [POS_W-1:0]        y_r  [NUM_BALLS];
  logic signed [VEL_W-1:0] vx_r [NUM_BALLS];
  logic signed [VEL_W-1:0] vy_r [NUM_BALLS];

  logic [POS_W-1:0]        nx, ny;
  logic signed [VEL_W-1:0] nvx, nvy;
  logic                    bx, by;

  assign tick = vsync & ~vsync_q;

  // One X and one Y stepper shared by all balls through the idx mux
  ball_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_step_x (
    .x(x_r[idx]), .v(vx_r[idx]), .max(XMAX),
    .x_next(nx), .v_next(nvx), .bounced(bx)
  );

  ball_step #(.POS_W(POS_W), .VEL_W(VEL_W)) u_step_y (
    .x(y_r[idx]), .v(vy_r[idx]), .max(YMAX),
    .x_next(ny), .v_next(nvy), .bounced(by)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      state        <= IDLE;
      idx          <= '0;
      bounce_event <= '0;
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
        x_r[i]  <= POS_W'(init_x(int'(i)));
        y_r[i]  <= POS_W'(init_y(int'(i)));
        vx_r[i] <= VEL_W'(init_vx(int'(i)));
        vy_r[i] <= VEL_W'(init_vy(int'(i)));
      end
    end else begin
      vsync_q      <= vsync;
      bounce_event <= '0;
      case (state)
        IDLE: begin
          if (tick && !pause) begin
            state <= UPDATE;
            idx   <= '0;
          end
        end
        UPDATE: begin
          if (ball_en[idx]) begin
            x_r[idx]          <= nx;
            y_r[idx]          <= ny;
            vx_r[idx]         <= nvx;
            vy_r[idx]         <= nvy;
            bounce_event[idx] <= bx | by;
          end
          if (idx == IDX_W'(NUM_BALLS - 1)) state <= IDLE;
          else                              idx   <= idx + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [2:0]       pix;
  logic             found;
  logic [POS_W-1:0] dx, dy;

  always_comb begin
    pix   = '0;
    found = 1'b0;
    dx    = '0;
    dy    = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      dx = hpos - x_r[i];
      dy = vpos - y_r[i];
      if (!found && ball_en[i] && (dx < BS) && (dy < BS)) begin
        pix   = ball_colour(int'(i));
        found = 1'b1;
      end
    end
    if (!found && (hpos[2:0] == 3'b000) && (vpos[2:0] == 3'b000)) pix = 3'b010;
    if (!display_on) pix = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb <= '0;
    else       rgb <= pix;
  end

endmodule

// File: tb/tb_ball_bounce_multi.sv
// Randomized self-checking bench for ball_bounce_multi against a frame-level model.
module tb_ball_bounce_multi;

  localparam int NB   = 4;
  localparam int BSZ  = 4;
  localparam int HA   = 256;
  localparam int VA   = 240;
  localparam int PW   = 9;
  localparam int VW   = 4;
  localparam int XM   = HA - BSZ;
  localparam int YM   = VA - BSZ;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          display_on;
  logic [PW-1:0] hpos;
  logic [PW-1:0] vpos;
  logic          pause;
  logic [NB-1:0] ball_en;
  logic [2:0]    rgb;
  logic [NB-1:0] bounce_event;

  ball_bounce_multi #(
    .NUM_BALLS(NB), .BALL_SIZE(BSZ), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .POS_W(PW), .VEL_W(VW)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .pause(pause), .ball_en(ball_en),
    .rgb(rgb), .bounce_event(bounce_event)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int mx [NB];
  int my [NB];
  int mvx[NB];
  int mvy[NB];
  int mb [NB];
  int bcnt[NB];

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i]  = 32 + 24 * i;
      my[i]  = 32 + 16 * i;
      mvx[i] = (i % 2 == 1) ? -(1 + i % 3) : (1 + i % 3);
      mvy[i] = (i % 4 >= 2) ? -2 : 2;
    end
  endfunction

  function automatic void axis(inout int p, inout int v, input int lim, output int b);
    int n;
    n = p + v;
    b = 0;
    if (n <= 0)        begin p = 0;   v = -v; b = 1; end
    else if (n >= lim) begin p = lim; v = -v; b = 1; end
    else                     p = n;
  endfunction

  function automatic void model_step();
    int b1, b2;
    for (int i = 0; i < NB; i++) begin
      mb[i] = 0;
      if (ball_en[i]) begin
        axis(mx[i], mvx[i], XM, b1);
        axis(my[i], mvy[i], YM, b2);
        mb[i] = (b1 | b2);
      end
    end
  endfunction

  function automatic int model_rgb(input int h, input int v, input int d);
    if (d == 0) return 0;
    for (int i = 0; i < NB; i++)
      if (ball_en[i] && (((h - mx[i]) & 511) < BSZ) && (((v - my[i]) & 511) < BSZ))
        return (i % 7) + 1;
    if ((h % 8) == 0 && (v % 8) == 0) return 2;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic render_check(input int h, input int v, input int d);
    hpos = PW'(h);
    vpos = PW'(v);
    display_on = d[0];
    step();
    check($sformatf("rgb h=%0d v=%0d d=%0d", h, v, d), int'(rgb), model_rgb(h, v, d));
  endtask

  task automatic random_render(input int n);
    int b, h, v;
    for (int k = 0; k < n; k++) begin
      b = $urandom_range(0, NB - 1);
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(0, 511);
        v = $urandom_range(0, 511);
      end else begin
        h = (mx[b] + $urandom_range(0, 7) - 2) & 511;
        v = (my[b] + $urandom_range(0, 7) - 2) & 511;
      end
      render_check(h, v, ($urandom_range(0, 7) != 0) ? 1 : 0);
    end
  endtask

  task automatic check_positions(input string tag);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s x%0d", tag, i),  int'(dut.x_r[i]),  mx[i]);
      check($sformatf("%s y%0d", tag, i),  int'(dut.y_r[i]),  my[i]);
      check($sformatf("%s vx%0d", tag, i), int'(dut.vx_r[i]), mvx[i]);
      check($sformatf("%s vy%0d", tag, i), int'(dut.vy_r[i]), mvy[i]);
    end
  endtask

  task automatic frame(input int p, input string tag);
    pause = p[0];
    vsync = 1'b1;
    for (int i = 0; i < NB; i++) bcnt[i] = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) vsync = 1'b0;
      for (int i = 0; i < NB; i++) bcnt[i] += int'(bounce_event[i]);
    end
    if (p == 0) model_step();
    else for (int i = 0; i < NB; i++) mb[i] = 0;
    for (int i = 0; i < NB; i++)
      check($sformatf("%s bounce%0d", tag, i), bcnt[i], mb[i]);
    check_positions(tag);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("reset rgb", int'(rgb), 0);
    check("reset bounce", int'(bounce_event), 0);
    check_positions("reset");
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; display_on = 1'b0; hpos = '0; vpos = '0;
    pause = 1'b0; ball_en = '1;
    step();
    apply_reset();

    render_check(32, 32, 1);
    check("t1 ball0 colour", int'(rgb), 1);
    render_check(56, 48, 1);
    check("t1 ball1 colour", int'(rgb), 2);
    render_check(56, 48, 0);
    check("t1 blank", int'(rgb), 0);

    frame(0, "f1");
    check("t2 x0", int'(dut.x_r[0]), 33);
    check("t2 y0", int'(dut.y_r[0]), 34);
    check("t2 x1", int'(dut.x_r[1]), 54);
    check("t2 y1", int'(dut.y_r[1]), 50);

    for (int f = 2; f <= 221; f++) begin
      frame(0, $sformatf("f%0d", f));
      random_render(2);
      if (f == 102) begin
        check("t3 y0", int'(dut.y_r[0]), 236);
        check("t3 vy0", int'(dut.vy_r[0]), -2);
        check("t3 pulse0", bcnt[0], 1);
      end
      if (f == 103) check("t3 y0 next", int'(dut.y_r[0]), 234);
      if (f == 220) begin
        check("t4 x0", int'(dut.x_r[0]), 252);
        check("t4 vx0", int'(dut.vx_r[0]), -1);
        check("t4 pulse0", bcnt[0], 1);
      end
      if (f == 221) check("t4 x0 next", int'(dut.x_r[0]), 251);
    end

    for (int k = 0; k < 3; k++) frame(1, "paused");
    frame(0, "unpause");

    // second rise lands while the sweep is still running and must be dropped
    pause = 1'b0;
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    vsync = 1'b1; step();
    vsync = 1'b0;
    for (int k = 0; k < 10; k++) step();
    model_step();
    check_positions("double tick");

    apply_reset();
    ball_en = 4'b1110;
    render_check(32, 32, 1);
    check("t6 disabled grid", int'(rgb), 2);
    frame(0, "ball0 off");
    check("t6 x0 frozen", int'(dut.x_r[0]), 32);
    check("t6 y0 frozen", int'(dut.y_r[0]), 32);

    for (int f = 0; f < 80; f++) begin
      ball_en = NB'($urandom_range(0, (1 << NB) - 1));
      frame(($urandom_range(0, 3) == 0) ? 1 : 0, $sformatf("rnd%0d", f));
      random_render(3);
    end

    ball_en = '1;
    pause = 1'b0;
    vsync = 1'b1; step();
    vsync = 1'b0; step();
    step();
    apply_reset();
    render_check(32, 32, 1);
    render_check(80, 64, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
